// File: rtl/debounce_pkg.sv
// Shared constants and types for the pushbutton debounce front end.
// Optional chord suppression is enabled with the DEBOUNCE_LOCKOUT_EN macro.
package debounce_pkg;

    localparam int unsigned N_BUTTONS_DEF    = 16;
    localparam int unsigned SYNC_STAGES_DEF  = 2;
    localparam int unsigned TICK_CYCLES_DEF  = 50000;
    localparam int unsigned STABLE_TICKS_DEF = 10;

    typedef logic [N_BUTTONS_DEF-1:0] btn_vec_t;

    // Counter width for a modulus n; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/debounce_lane.sv
// One button lane: raw-pin synchroniser, stability integrator and press strobe.
// Under DEBOUNCE_LOCKOUT_EN the lane also exports its same-tick press request
// so the top level can arbitrate between lanes.
module debounce_lane
    import debounce_pkg::*;
#(
    parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw_i,
    input  logic tick_i,
    input  logic commit_en_i,
    output logic level_o,
    output logic press_pulse_o
`ifdef DEBOUNCE_LOCKOUT_EN
    ,
    output logic press_request_c_o
`endif
);

    localparam int unsigned CNT_W = cnt_width(STABLE_TICKS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_TICKS - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   press_q, press_d;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser, integrator and level/strobe registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q  <= '1;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_raw_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    // Qualification: any return to the committed level restarts the count;
    // a blocked press keeps the count at zero.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        if (s == level_q) begin
            cnt_d = '0;
        end else if (!s && !commit_en_i) begin
            cnt_d = '0;
        end else if (tick_i && (cnt_q == CNT_LAST)) begin
            level_d = s;
            cnt_d   = '0;
        end else if (tick_i) begin
            cnt_d = CNT_W'(cnt_q + 1'b1);
        end
        press_d = level_q & ~level_d;
    end

`ifdef DEBOUNCE_LOCKOUT_EN
    // A press would commit on this tick if the lane were allowed to.
    assign press_request_c_o = !s && level_q && tick_i && (cnt_q == CNT_LAST);
`endif

    assign level_o       = level_q;
    assign press_pulse_o = press_q;

endmodule

// File: rtl/button_debounce.sv
// Debounces N active-low pushbuttons into the clk domain for the button encoder.
// Define DEBOUNCE_LOCKOUT_EN to suppress chords so that at most one lane is
// ever low (lowest index wins simultaneous presses).
module button_debounce
    import debounce_pkg::*;
#(
    parameter int unsigned N_BUTTONS    = N_BUTTONS_DEF,
    parameter int unsigned SYNC_STAGES  = SYNC_STAGES_DEF,
    parameter int unsigned TICK_CYCLES  = TICK_CYCLES_DEF,
    parameter int unsigned STABLE_TICKS = STABLE_TICKS_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] buttons_raw,
    output logic [N_BUTTONS-1:0] buttons,
    output logic [N_BUTTONS-1:0] press_pulse,
    output logic                 any_pressed
);

    localparam int unsigned PRE_W = cnt_width(TICK_CYCLES);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_CYCLES - 1);

    logic [PRE_W-1:0]     pre_q, pre_d;
    logic                 tick_c;
    logic [N_BUTTONS-1:0] commit_en;

    assign tick_c = (pre_q == PRE_LAST);

    // Sample-tick prescaler register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    // Prescaler wraps after TICK_CYCLES-1.
    always_comb begin
        pre_d = tick_c ? '0 : PRE_W'(pre_q + 1'b1);
    end

`ifdef DEBOUNCE_LOCKOUT_EN
    logic [N_BUTTONS-1:0] press_req;
    logic [N_BUTTONS-1:0] lane_mask;
    logic                 lower_req;

    // Lockout: a lane may commit a press only when no other lane is low and
    // no lower-index lane is committing a press on the same tick.
    always_comb begin
        commit_en = '0;
        lane_mask = '0;
        lower_req = 1'b0;
        for (int i = 0; i < int'(N_BUTTONS); i++) begin
            lane_mask    = '0;
            lane_mask[i] = 1'b1;
            commit_en[i] = ~(|(~buttons & ~lane_mask)) & ~lower_req;
            lower_req    = lower_req | press_req[i];
        end
    end
`else
    assign commit_en = '1;
`endif

    for (genvar g = 0; g < int'(N_BUTTONS); g++) begin : g_lane
        debounce_lane #(
            .SYNC_STAGES (SYNC_STAGES),
            .STABLE_TICKS(STABLE_TICKS)
        ) u_lane (
            .clk              (clk),
            .reset            (reset),
            .btn_raw_i        (buttons_raw[g]),
            .tick_i           (tick_c),
            .commit_en_i      (commit_en[g]),
            .level_o          (buttons[g]),
            .press_pulse_o    (press_pulse[g])
`ifdef DEBOUNCE_LOCKOUT_EN
            ,
            .press_request_c_o(press_req[g])
`endif
        );
    end

    assign any_pressed = ~&buttons;

endmodule

// File: tb/tb_button_debounce.sv
// Directed bench for button_debounce with SYNC_STAGES=2, TICK_CYCLES=4, STABLE_TICKS=3.
// Expected commit latency after a raw edge is 11..14 clk edges.
module tb_button_debounce;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] raw;
    logic [15:0] buttons;
    logic [15:0] press_pulse;
    logic        any_pressed;

    int checks   = 0;
    int failures = 0;
    int pcnt [16];
    int n;
    int p0;
    logic bounce_ok;

    button_debounce #(
        .N_BUTTONS   (16),
        .SYNC_STAGES (2),
        .TICK_CYCLES (4),
        .STABLE_TICKS(3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .buttons_raw(raw),
        .buttons    (buttons),
        .press_pulse(press_pulse),
        .any_pressed(any_pressed)
    );

    always #5 clk = ~clk;

    // Count strobe cycles per lane, sampled away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 16; i++) begin
            if (press_pulse[i] === 1'b1) pcnt[i] = pcnt[i] + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_range(input string tag, input int v, input int lo, input int hi);
        checks++;
        assert (v >= lo && v <= hi) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d..%0d", tag, v, lo, hi);
        end
    endtask

    task automatic step(input int cyc);
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    // Count edges until buttons reads exp, giving up after maxc edges.
    task automatic wait_for(input logic [15:0] exp, input int maxc, output int cnt);
        cnt = 0;
        do begin
            @(posedge clk);
            #1;
            cnt++;
        end while (buttons !== exp && cnt < maxc);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) pcnt[i] = 0;
        reset = 1'b1;
        raw   = 16'h0000;

        // Reset dominates a fully pressed raw vector.
        step(5);
        chk("rst_buttons", 32'(buttons), 32'hFFFF);
        chk("rst_pulse", 32'(press_pulse), 32'h0);
        chk("rst_any", 32'(any_pressed), 32'h0);
        step(3);
        chk("rst_buttons_late", 32'(buttons), 32'hFFFF);

        raw = 16'hFFFF;
        step(2);
        reset = 1'b0;
        step(12);
        chk("idle_buttons", 32'(buttons), 32'hFFFF);

        // Single press on lane 0.
        raw = 16'hFFFE;
        wait_for(16'hFFFE, 30, n);
        chk_range("press0_latency", n, 11, 14);
        chk("press0_buttons", 32'(buttons), 32'hFFFE);
        chk("press0_pulse", 32'(press_pulse), 32'h0001);
        chk("press0_any", 32'(any_pressed), 32'h1);
        step(1);
        chk("press0_pulse_gone", 32'(press_pulse), 32'h0);
        step(5);
        chk("press0_pulse_count", 32'(pcnt[0]), 32'd1);

        // Release lane 0.
        raw = 16'hFFFF;
        wait_for(16'hFFFF, 30, n);
        chk_range("release0_latency", n, 11, 14);
        chk("release0_buttons", 32'(buttons), 32'hFFFF);
        chk("release0_pulse", 32'(press_pulse), 32'h0);
        chk("release0_any", 32'(any_pressed), 32'h0);
        step(3);
        chk("release0_pulse_count", 32'(pcnt[0]), 32'd1);

        // Lane 3 bounces every 3 cycles, then settles low.
        bounce_ok = 1'b1;
        for (int k = 0; k < 14; k++) begin
            raw[3] = k[0];
            for (int c = 0; c < 3; c++) begin
                @(posedge clk);
                #1;
                if (buttons[3] !== 1'b1) bounce_ok = 1'b0;
            end
        end
        chk("bounce3_held_high", 32'(bounce_ok), 32'h1);
        chk("bounce3_no_pulse", 32'(pcnt[3]), 32'd0);
        raw[3] = 1'b0;
        wait_for(16'hFFF7, 30, n);
        chk_range("bounce3_latency", n, 11, 14);
        chk("bounce3_buttons", 32'(buttons), 32'hFFF7);
        step(3);
        chk("bounce3_pulse_count", 32'(pcnt[3]), 32'd1);
        raw = 16'hFFFF;
        wait_for(16'hFFFF, 30, n);
        chk("bounce3_release", 32'(buttons), 32'hFFFF);

        // Lane 1 joins a held lane 0 twenty cycles later.
        raw = 16'hFFFE;
        step(20);
        chk("chord_first", 32'(buttons), 32'hFFFE);
        raw = 16'hFFFC;
`ifdef DEBOUNCE_LOCKOUT_EN
        step(30);
        chk("chord_locked", 32'(buttons), 32'hFFFE);
        chk("chord_lane1_pulse", 32'(pcnt[1]), 32'd0);
`else
        wait_for(16'hFFFC, 30, n);
        chk_range("chord_latency", n, 11, 14);
        chk("chord_buttons", 32'(buttons), 32'hFFFC);
        step(2);
        chk("chord_lane1_pulse", 32'(pcnt[1]), 32'd1);
`endif
        raw = 16'hFFFF;
        wait_for(16'hFFFF, 40, n);
        chk("chord_release", 32'(buttons), 32'hFFFF);

        // Lanes 1 and 2 pressed on the same cycle.
        p0 = pcnt[2];
`ifdef DEBOUNCE_LOCKOUT_EN
        raw = 16'hFFF9;
        wait_for(16'hFFFD, 30, n);
        chk("simul_buttons", 32'(buttons), 32'hFFFD);
        step(20);
        chk("simul_buttons_late", 32'(buttons), 32'hFFFD);
        chk("simul_lane2_pulse", 32'(pcnt[2] - p0), 32'd0);
`else
        raw = 16'hFFF9;
        wait_for(16'hFFF9, 30, n);
        chk("simul_buttons", 32'(buttons), 32'hFFF9);
        step(20);
        chk("simul_buttons_late", 32'(buttons), 32'hFFF9);
        chk("simul_lane2_pulse", 32'(pcnt[2] - p0), 32'd1);
`endif
        raw = 16'hFFFF;
        wait_for(16'hFFFF, 40, n);
        chk("simul_release", 32'(buttons), 32'hFFFF);
        raw = 16'hFFFB;
        wait_for(16'hFFFB, 30, n);
        chk_range("lane2_latency", n, 11, 14);
        chk("lane2_buttons", 32'(buttons), 32'hFFFB);
        raw = 16'hFFFF;
        wait_for(16'hFFFF, 30, n);
        chk("lane2_release", 32'(buttons), 32'hFFFF);

        // Reset in mid-qualification, button held across reset release.
        p0  = pcnt[0];
        raw = 16'hFFFE;
        step(8);
        reset = 1'b1;
        step(1);
        chk("midrst_buttons", 32'(buttons), 32'hFFFF);
        chk("midrst_pulse", 32'(press_pulse), 32'h0);
        chk("midrst_any", 32'(any_pressed), 32'h0);
        step(1);
        reset = 1'b0;
        wait_for(16'hFFFE, 30, n);
        chk_range("midrst_latency", n, 11, 14);
        chk("midrst_fresh_press", 32'(buttons), 32'hFFFE);
        step(2);
        chk("midrst_pulse_count", 32'(pcnt[0] - p0), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
